// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss/refill sequencer for a 2-way set-associative cache.
// Hits update the LRU bit; misses pick the LRU way as victim, optionally write
// back a dirty victim, then refill the line beat by beat into the data array.
// Build option: define CACHE_REFILL_WRITEBACK_EN to include the writeback path
// (WB_REQ/WB_DATA). Without it the cache is write-through and never writes back.
module cache_refill_ctrl #(
  parameter  int INDEX_BITS = 8,
  parameter  int BEATS      = 4,
  parameter  int DATA_W     = 32,
  localparam int BEAT_W     = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [INDEX_BITS-1:0] i_req_index,
  input  logic                  i_req_hit,
  input  logic                  i_req_hit_way,
  input  logic [1:0]            i_req_victim_dirty,
  output logic [INDEX_BITS-1:0] o_lru_sel,
  input  logic                  i_lru_way,
  output logic                  o_lru_update,
  output logic                  o_lru_ref,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic                  o_mem_req_write,
  output logic [INDEX_BITS-1:0] o_mem_req_index,
  output logic                  o_mem_wdata_valid,
  output logic [DATA_W-1:0]     o_mem_wdata,
  input  logic                  i_mem_rdata_valid,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic                  o_arr_we,
  output logic                  o_arr_re,
  output logic                  o_arr_way,
  output logic [INDEX_BITS-1:0] o_arr_index,
  output logic [BEAT_W-1:0]     o_arr_beat,
  output logic [DATA_W-1:0]     o_arr_wdata,
  input  logic [DATA_W-1:0]     i_arr_rdata,
  output logic                  o_done_valid,
  output logic                  o_done_way
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HIT     = 3'd1,
    S_VICTIM  = 3'd2,
`ifdef CACHE_REFILL_WRITEBACK_EN
    S_WB_REQ  = 3'd3,
    S_WB_DATA = 3'd4,
`endif
    S_RF_REQ  = 3'd5,
    S_RF_DATA = 3'd6,
    S_UPDATE  = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [INDEX_BITS-1:0] r_index;
  logic                  r_hit_way;
  logic                  r_victim;
  logic [BEAT_W-1:0]     r_cnt;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;

`ifdef CACHE_REFILL_WRITEBACK_EN
  logic [1:0]            r_dirty;
  logic                  r_wdata_valid;

  // Latch the set's dirty bits at acceptance; they pick the writeback path in VICTIM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty <= 2'b00;
    end else if (r_state == S_IDLE && i_req_valid) begin
      r_dirty <= i_req_victim_dirty;
    end else begin
      r_dirty <= r_dirty;
    end
  end

  // Array read data appears one cycle after arr_re, so the beat valid lags by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdata_valid <= 1'b0;
    end else begin
      r_wdata_valid <= o_arr_re;
    end
  end

  assign o_mem_wdata_valid = r_wdata_valid;
  assign o_mem_wdata       = r_wdata_valid ? i_arr_rdata : {DATA_W{1'b0}};
`else
  logic w_unused;
  assign w_unused          = ^{i_req_victim_dirty, i_arr_rdata};
  assign o_mem_wdata_valid = 1'b0;
  assign o_mem_wdata       = {DATA_W{1'b0}};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request fields captured on acceptance; victim captured from the LRU store in VICTIM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index   <= {INDEX_BITS{1'b0}};
      r_hit_way <= 1'b0;
      r_victim  <= 1'b0;
    end else if (r_state == S_IDLE && i_req_valid) begin
      r_index   <= i_req_index;
      r_hit_way <= i_req_hit_way;
      r_victim  <= r_victim;
    end else if (r_state == S_VICTIM) begin
      r_index   <= r_index;
      r_hit_way <= r_hit_way;
      r_victim  <= i_lru_way;
    end else begin
      r_index   <= r_index;
      r_hit_way <= r_hit_way;
      r_victim  <= r_victim;
    end
  end

  // Beat counter: cleared when a data phase starts, wraps naturally at BEATS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {BEAT_W{1'b0}};
    end else if (w_cnt_clr) begin
      r_cnt <= {BEAT_W{1'b0}};
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + BEAT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Next-state and state-decoded outputs; refill strobes follow mem_rdata_valid directly.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_clr       = 1'b0;
    w_cnt_inc       = 1'b0;
    o_req_ready     = 1'b0;
    o_lru_sel       = r_index;
    o_lru_update    = 1'b0;
    o_lru_ref       = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_req_write = 1'b0;
    o_mem_req_index = r_index;
    o_arr_we        = 1'b0;
    o_arr_re        = 1'b0;
    o_arr_way       = r_victim;
    o_arr_index     = r_index;
    o_arr_beat      = {BEAT_W{1'b0}};
    o_arr_wdata     = {DATA_W{1'b0}};
    o_done_valid    = 1'b0;
    o_done_way      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready     = 1'b1;
        o_lru_sel       = i_req_index;
        o_mem_req_index = {INDEX_BITS{1'b0}};
        o_arr_index     = {INDEX_BITS{1'b0}};
        o_arr_way       = 1'b0;
        if (i_req_valid) begin
          w_state_nxt = i_req_hit ? S_HIT : S_VICTIM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HIT: begin
        o_lru_update = 1'b1;
        o_lru_ref    = r_hit_way;
        o_done_valid = 1'b1;
        o_done_way   = r_hit_way;
        w_state_nxt  = S_IDLE;
      end
      S_VICTIM: begin
`ifdef CACHE_REFILL_WRITEBACK_EN
        if (r_dirty[i_lru_way]) begin
          w_state_nxt = S_WB_REQ;
        end else begin
          w_state_nxt = S_RF_REQ;
        end
`else
        w_state_nxt = S_RF_REQ;
`endif
      end
`ifdef CACHE_REFILL_WRITEBACK_EN
      S_WB_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_write = 1'b1;
        if (i_mem_req_ready) begin
          w_state_nxt = S_WB_DATA;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = S_WB_REQ;
        end
      end
      S_WB_DATA: begin
        o_arr_re   = 1'b1;
        o_arr_beat = r_cnt;
        w_cnt_inc  = 1'b1;
        if (r_cnt == LAST_BEAT) begin
          w_state_nxt = S_RF_REQ;
        end else begin
          w_state_nxt = S_WB_DATA;
        end
      end
`endif
      S_RF_REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) begin
          w_state_nxt = S_RF_DATA;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = S_RF_REQ;
        end
      end
      S_RF_DATA: begin
        if (i_mem_rdata_valid) begin
          o_arr_we    = 1'b1;
          o_arr_wdata = i_mem_rdata;
          o_arr_beat  = r_cnt;
          w_cnt_inc   = 1'b1;
          if (r_cnt == LAST_BEAT) begin
            w_state_nxt = S_UPDATE;
          end else begin
            w_state_nxt = S_RF_DATA;
          end
        end else begin
          w_state_nxt = S_RF_DATA;
        end
      end
      S_UPDATE: begin
        o_lru_update = 1'b1;
        o_lru_ref    = r_victim;
        o_done_valid = 1'b1;
        o_done_way   = r_victim;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: randomized lookups against a
// line/LRU reference model, with scoreboard queues popped by output monitors.
module tb_cache_refill_ctrl;

  localparam int IB = 8;
  localparam int BEATS = 4;
  localparam int DW = 32;
`ifdef CACHE_REFILL_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          i_req_valid = 1'b0, o_req_ready;
  logic [IB-1:0] i_req_index = '0;
  logic          i_req_hit = 1'b0, i_req_hit_way = 1'b0;
  logic [1:0]    i_req_victim_dirty = 2'b00;
  logic [IB-1:0] o_lru_sel;
  logic          i_lru_way, o_lru_update, o_lru_ref;
  logic          o_mem_req_valid, o_mem_req_write;
  logic          i_mem_req_ready = 1'b0;
  logic [IB-1:0] o_mem_req_index;
  logic          o_mem_wdata_valid;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_rdata_valid = 1'b0;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          o_arr_we, o_arr_re, o_arr_way;
  logic [IB-1:0] o_arr_index;
  logic [1:0]    o_arr_beat;
  logic [DW-1:0] o_arr_wdata;
  logic [DW-1:0] arr_rdata = '0;
  logic          o_done_valid, o_done_way;

  cache_refill_ctrl #(.INDEX_BITS(IB), .BEATS(BEATS), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_index(i_req_index),
    .i_req_hit(i_req_hit), .i_req_hit_way(i_req_hit_way), .i_req_victim_dirty(i_req_victim_dirty),
    .o_lru_sel(o_lru_sel), .i_lru_way(i_lru_way), .o_lru_update(o_lru_update), .o_lru_ref(o_lru_ref),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_write(o_mem_req_write), .o_mem_req_index(o_mem_req_index),
    .o_mem_wdata_valid(o_mem_wdata_valid), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata_valid(i_mem_rdata_valid), .i_mem_rdata(i_mem_rdata),
    .o_arr_we(o_arr_we), .o_arr_re(o_arr_re), .o_arr_way(o_arr_way), .o_arr_index(o_arr_index),
    .o_arr_beat(o_arr_beat), .o_arr_wdata(o_arr_wdata), .i_arr_rdata(arr_rdata),
    .o_done_valid(o_done_valid), .o_done_way(o_done_way)
  );

  typedef struct { int idx; int way; int icyc; int lat; } done_t;
  typedef struct { bit wr; int idx; } mreq_t;
  typedef struct { int way; int idx; int beat; logic [31:0] d; } aw_t;

  done_t       done_q[$];
  mreq_t       mq[$];
  aw_t         aw_q[$];
  logic [31:0] wd_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int aw_seen = 0;
  int done_cnt = 0;

  // Stimulus/responder controls (written only by the main initial block)
  localparam int M_ZERO = 0, M_DIR = 1, M_RAND = 2;
  int mode = M_ZERO;
  bit stray_en = 1'b0;
  bit garbage_en = 1'b0;

  function automatic logic [31:0] init_val(int w, int i, int b);
    return {8'hC0, 7'd0, 1'(w), 8'(i), 8'(b)};
  endfunction

  function automatic logic [31:0] refill_data(int seq, int b);
    logic [31:0] s;
    s = 32'(seq * BEATS + b + 1);
    return (s * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: LRU store (records complement of the referenced way)
  bit lru_ram [256];
  assign i_lru_way = lru_ram[o_lru_sel];
  always @(posedge clk) begin
    if (o_lru_update) lru_ram[o_lru_sel] <= ~o_lru_ref;
  end

  // Environment: data array, synchronous read
  logic [31:0] ram [2][256][BEATS];
  bit          written [2][256][BEATS];
  always @(posedge clk) begin
    if (o_arr_we) begin
      ram[o_arr_way][o_arr_index][o_arr_beat] <= o_arr_wdata;
      written[o_arr_way][o_arr_index][o_arr_beat] <= 1'b1;
    end
    if (o_arr_re) begin
      arr_rdata <= written[o_arr_way][o_arr_index][o_arr_beat] ?
                   ram[o_arr_way][o_arr_index][o_arr_beat] :
                   init_val(int'(o_arr_way), int'(o_arr_index), int'(o_arr_beat));
    end
  end

  // Environment: memory responder, drives #1 after the clock edge
  int rd_left = 0;
  int wait_ctr = -1;
  int rsp_seq = 0;
  bit gap_done = 1'b0;
  always @(posedge clk) begin
    bit give;
    #1;
    i_mem_req_ready   = 1'b0;
    i_mem_rdata_valid = 1'b0;
    if (rd_left > 0) begin
      if (mode == M_ZERO) give = 1'b1;
      else if (mode == M_DIR) give = !(rd_left == 2 && !gap_done);
      else give = ($urandom_range(0, 2) != 0);
      if (!give && mode == M_DIR) gap_done = 1'b1;
      if (give) begin
        i_mem_rdata_valid = 1'b1;
        i_mem_rdata = refill_data(rsp_seq - 1, BEATS - rd_left);
        rd_left--;
      end
    end else if (o_mem_req_valid) begin
      if (wait_ctr < 0)
        wait_ctr = (mode == M_ZERO) ? 0 : (mode == M_DIR) ? 3 : int'($urandom_range(0, 3));
      if (wait_ctr == 0) begin
        i_mem_req_ready = 1'b1;
        wait_ctr = -1;
        if (!o_mem_req_write) begin
          rd_left  = BEATS;
          rsp_seq++;
          gap_done = 1'b0;
        end
      end else begin
        wait_ctr--;
      end
    end else if (stray_en) begin
      i_mem_rdata_valid = 1'($urandom_range(0, 1));
      i_mem_rdata = $urandom;
    end
  end

  // Monitor: completion pulses
  always @(negedge clk) begin
    done_t e;
    if (o_done_valid) begin
      done_cnt++;
      chk("lru_update_with_done", {63'd0, o_lru_update}, 64'd1);
      if (done_q.size() == 0) begin
        fail_now("unexpected done_valid");
      end else begin
        e = done_q.pop_front();
        chk("done_way", {63'd0, o_done_way}, 64'(e.way));
        chk("lru_ref", {63'd0, o_lru_ref}, 64'(e.way));
        chk("lru_sel", {56'd0, o_lru_sel}, 64'(e.idx));
        if (e.lat != 0) chk("latency", 64'(cyc - e.icyc), 64'(e.lat));
      end
    end else if (o_lru_update) begin
      fail_now("lru_update without done_valid");
    end
  end

  // Monitor: memory commands
  always @(negedge clk) begin
    mreq_t m;
    if (o_mem_req_valid && i_mem_req_ready) begin
      if (mq.size() == 0) begin
        fail_now("unexpected mem request");
      end else begin
        m = mq.pop_front();
        chk("mem_req_write", {63'd0, o_mem_req_write}, 64'(m.wr));
        chk("mem_req_index", {56'd0, o_mem_req_index}, 64'(m.idx));
      end
    end
  end

  // Monitor: writeback beats
  always @(negedge clk) begin
    logic [31:0] d;
    if (o_mem_wdata_valid) begin
      if (wd_q.size() == 0) begin
        fail_now("unexpected mem_wdata_valid");
      end else begin
        d = wd_q.pop_front();
        chk("mem_wdata", {32'd0, o_mem_wdata}, {32'd0, d});
      end
    end
  end

  // Monitor: array refill writes
  always @(negedge clk) begin
    aw_t a;
    if (o_arr_we) begin
      aw_seen++;
      if (aw_q.size() == 0) begin
        fail_now("unexpected arr_we");
      end else begin
        a = aw_q.pop_front();
        chk("arr_we way/index/beat",
            {45'd0, o_arr_way, o_arr_index, 8'(o_arr_beat), 2'd0},
            {45'd0, 1'(a.way), 8'(a.idx), 8'(a.beat), 2'd0});
        chk("arr_wdata", {32'd0, o_arr_wdata}, {32'd0, a.d});
      end
    end
  end

  // Reference model state
  bit          m_lru [256];
  logic [31:0] m_arr [2][256][BEATS];
  int          rf_seq = 0;

  task automatic drive_idle();
    if (!o_req_ready && garbage_en) begin
      i_req_valid        = 1'($urandom_range(0, 1));
      i_req_index        = 8'($urandom);
      i_req_hit          = 1'($urandom);
      i_req_hit_way      = 1'($urandom);
      i_req_victim_dirty = 2'($urandom);
    end else begin
      i_req_valid = 1'b0;
    end
  endtask

  task automatic flush_all();
    done_q.delete(); mq.delete(); aw_q.delete(); wd_q.delete();
  endtask

  // Called at posedge+1; returns one cycle after acceptance
  task automatic issue(input int idx, input bit hit, input bit hw, input logic [1:0] dirty,
                       input int lat);
    done_t de;
    int n = 0;
    int v;
    while (!o_req_ready && n < 500) begin
      drive_idle();
      @(posedge clk); #1;
      n++;
    end
    if (!o_req_ready) begin
      fail_now("timeout waiting for req_ready");
      return;
    end
    i_req_valid = 1'b1; i_req_index = 8'(idx); i_req_hit = hit;
    i_req_hit_way = hw; i_req_victim_dirty = dirty;
    de.idx = idx; de.icyc = cyc; de.lat = lat;
    if (hit) begin
      de.way = hw;
      m_lru[idx] = !hw;
    end else begin
      v = int'(m_lru[idx]);
      if (WB && dirty[v]) begin
        mq.push_back('{1'b1, idx});
        for (int b = 0; b < BEATS; b++) wd_q.push_back(m_arr[v][idx][b]);
      end
      mq.push_back('{1'b0, idx});
      for (int b = 0; b < BEATS; b++) begin
        aw_q.push_back('{v, idx, b, refill_data(rf_seq, b)});
        m_arr[v][idx][b] = refill_data(rf_seq, b);
      end
      rf_seq++;
      m_lru[idx] = (v == 0);
      de.way = v;
    end
    done_q.push_back(de);
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      drive_idle();
      n++;
    end
    if (done_q.size() != 0) begin
      fail_now("timeout waiting for done_valid");
      flush_all();
    end
    chk("req_ready after done", {63'd0, o_req_ready}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " strobes"},
        {53'd0, o_req_ready, o_lru_update, o_mem_req_valid, o_mem_wdata_valid, o_arr_we,
         o_arr_re, o_done_valid, o_mem_req_write, o_lru_ref, o_done_way, o_arr_way},
        {53'd0, 11'b100_0000_0000});
    chk({tag, " index/beat"}, {38'd0, o_mem_req_index, o_arr_index, 8'(o_arr_beat), 2'd0}, 64'd0);
    chk({tag, " data"}, {o_arr_wdata, o_mem_wdata}, 64'd0);
  endtask

  initial begin
    int dc;
    int n;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 256; i++)
        for (int b = 0; b < BEATS; b++) m_arr[w][i][b] = init_val(w, i, b);

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset in the middle of a refill: aborts without lru_update or done
    mode = M_RAND;
    issue(12, 1'b0, 1'b0, 2'b00, 0);
    dc = done_cnt;
    n = 0;
    while (aw_seen < 2 && n < 300) begin @(negedge clk); n++; end
    if (aw_seen < 2) fail_now("timeout waiting for refill beats");
    @(posedge clk); #2;
    rst_n = 1'b0;
    i_req_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid-refill reset");
    flush_all();
    @(negedge clk);
    check_reset_outputs("mid-refill reset hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("idle after abort (arr_we, done)", {62'd0, o_arr_we, o_done_valid}, 64'd0);
    end
    chk("no done pulse for aborted miss", 64'(done_cnt), 64'(dc));
    @(posedge clk); #1;

    // Hit at index 3 after reset, then the directed hit at index 5 way 1
    mode = M_ZERO;
    issue(3, 1'b1, 1'b0, 2'b00, 1);
    wait_done();
    issue(5, 1'b1, 1'b1, 2'b00, 1);
    wait_done();

    // Clean miss at 0x2A into way 0, memory ready after 3 cycles, one gap
    mode = M_DIR;
    issue(8'h2A, 1'b0, 1'b0, 2'b00, 0);
    wait_done();

    // Clean miss, zero-wait memory: fixed latency
    mode = M_ZERO;
    issue(8'h40, 1'b0, 1'b0, 2'b11, WB ? 0 : 3 + BEATS);
    wait_done();
    issue(8'h41, 1'b0, 1'b0, 2'b10, 3 + BEATS);
    wait_done();

    // Dirty miss: make way 1 the LRU victim of 0x31, then miss with dirty=2'b10
    issue(8'h31, 1'b1, 1'b0, 2'b00, 1);
    wait_done();
    issue(8'h31, 1'b0, 1'b0, 2'b10, WB ? 4 + 2 * BEATS : 3 + BEATS);
    wait_done();

    // Randomized traffic with stray memory beats and req_valid held while busy
    mode = M_RAND;
    stray_en = 1'b1;
    garbage_en = 1'b1;
    for (int t = 0; t < 60; t++) begin
      issue(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom),
            2'($urandom), 0);
      wait_done();
    end
    stray_en = 1'b0;
    garbage_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    chk("leftover done expectations", 64'(done_q.size()), 64'd0);
    chk("leftover mem requests", 64'(mq.size()), 64'd0);
    chk("leftover writeback beats", 64'(wd_q.size()), 64'd0);
    chk("leftover refill writes", 64'(aw_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
